// File: rtl/calc_sched.sv
// Operation scheduler for the UART calculator: captures one parsed request, starts one
// arithmetic unit, waits for its done pulse (div-by-zero and timeout guarded), then hands the result to TX.
module calc_sched #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          parser_done,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  output logic          busy,
  output logic [3:0]    unit_start,
  output logic [DW-1:0] unit_src1,
  output logic [DW-1:0] unit_src2,
  input  logic [3:0]    unit_done,
  input  logic [31:0]   add_res,
  input  logic [31:0]   sub_res,
  input  logic [31:0]   mul_res,
  input  logic [31:0]   div_res,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [1:0]    res_err,
  output logic          req_drop
);

  // Result handshake: res_valid is a pure function of the registered state, so it never
  // depends on res_ready; a transfer happens on any clk edge where res_valid & res_ready.
  // res_data/res_err are held stable from the rise of res_valid until that transfer.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  ERR_OK     = 2'b00;
  localparam logic [1:0]  ERR_DIV0   = 2'b01;
  localparam logic [1:0]  ERR_TMO    = 2'b10;

  state_t        state_q, state_d;
  logic          d1_q, d2_q;
  logic          edge_start;
  logic [1:0]    op_q;
  logic [DW-1:0] src1_q, src2_q;
  logic [15:0]   timer_q;
  logic [31:0]   res_data_q;
  logic [1:0]    res_err_q;
  logic          div_zero;
  logic          sel_done;
  logic          timer_expired;
  logic [31:0]   sel_res;

  assign edge_start    = d1_q & ~d2_q;
  assign div_zero      = (op_q == 2'd3) && (src2_q == '0);
  assign sel_done      = unit_done[op_q];
  assign timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    sel_res = add_res;
    case (op_q)
      2'd1:    sel_res = sub_res;
      2'd2:    sel_res = mul_res;
      2'd3:    sel_res = div_res;
      default: sel_res = add_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Done is tested before the timer so a done on the last WAIT cycle still completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (edge_start) state_d = S_ISSUE;
      S_ISSUE: state_d = div_zero ? S_OUT : S_WAIT;
      S_WAIT:  if (sel_done || timer_expired) state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    res_valid  = (state_q == S_OUT);
    req_drop   = edge_start && (state_q != S_IDLE);
    unit_start = 4'b0000;
    if ((state_q == S_ISSUE) && !div_zero) begin
      unit_start = 4'b0001 << op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q       <= 1'b0;
      d2_q       <= 1'b0;
      op_q       <= 2'd0;
      src1_q     <= '0;
      src2_q     <= '0;
      timer_q    <= 16'd0;
      res_data_q <= 32'd0;
      res_err_q  <= ERR_OK;
    end else begin
      d1_q <= parser_done;
      d2_q <= d1_q;
      if ((state_q == S_IDLE) && edge_start) begin
        op_q   <= op;
        src1_q <= src1;
        src2_q <= src2;
      end
      case (state_q)
        S_ISSUE: begin
          timer_q <= 16'd0;
          if (div_zero) begin
            res_data_q <= 32'd0;
            res_err_q  <= ERR_DIV0;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + 16'd1;
          if (sel_done) begin
            res_data_q <= sel_res;
            res_err_q  <= ERR_OK;
          end else if (timer_expired) begin
            res_data_q <= 32'd0;
            res_err_q  <= ERR_TMO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign unit_src1 = src1_q;
  assign unit_src2 = src2_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

  // At most one unit is ever started, and a stalled result must not move.
  a_start_onehot: assert property (@(posedge clk) $onehot0(unit_start));
  a_res_stable: assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_err)));

endmodule
